// File: rtl/mem_align_unit.sv
// Load/store alignment unit between the MEM stage and a synchronous data memory.
// Builds byte enables and lane-replicated store data, and extends load data back to 32 bits.
module mem_align_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_exc,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        addr_exc_q, addr_exc_d;

    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane select and extension use the captured request, not the live req_* inputs.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        addr_exc_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    if (misaligned) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        addr_exc_d   = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        mem_en_d   = 1'b1;
                        mem_we_d   = req_we;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (!req_we) begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = req_wdata;
                        end else begin
                            case (req_size)
                                2'd0: begin
                                    mem_be_d    = 4'b0001 << req_addr[1:0];
                                    mem_wdata_d = {4{req_wdata[7:0]}};
                                end
                                2'd1: begin
                                    mem_be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = 4'b1111;
                                    mem_wdata_d = req_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = 2'd0;
                if (we_q) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            lane_q       <= 2'd0;
            cnt_q        <= 2'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            addr_exc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            addr_exc_q   <= addr_exc_d;
        end
    end

    assign stall      = req_valid && (state_q != S_DONE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign addr_exc   = addr_exc_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: one instance at latency 1, one at latency 3,
// sharing a byte-enabled memory model and a response scoreboard per instance.
module tb_mem_align_unit;

    logic        clk;
    logic        reset;
    logic        valid_a, valid_b;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        stall_a, resp_valid_a, addr_exc_a, mem_en_a, mem_we_a;
    logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [3:0]  mem_be_a;
    logic        stall_b, resp_valid_b, addr_exc_b, mem_en_b, mem_we_b;
    logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [3:0]  mem_be_b;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        exc;
    } exp_t;

    typedef struct {
        int          lat;
        int          en_at;
        int          stall_cnt;
        int          en_cnt;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic        mwe;
    } obs_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rda_q;
    logic [31:0] rdb_pipe [3];

    mem_align_unit #(.MEM_LATENCY(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid_a),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall_a),
        .resp_valid (resp_valid_a),
        .resp_rdata (resp_rdata_a),
        .addr_exc   (addr_exc_a),
        .mem_en     (mem_en_a),
        .mem_we     (mem_we_a),
        .mem_addr   (mem_addr_a),
        .mem_be     (mem_be_a),
        .mem_wdata  (mem_wdata_a),
        .mem_rdata  (mem_rdata_a)
    );

    mem_align_unit #(.MEM_LATENCY(3)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid_b),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall_b),
        .resp_valid (resp_valid_b),
        .resp_rdata (resp_rdata_b),
        .addr_exc   (addr_exc_b),
        .mem_en     (mem_en_b),
        .mem_we     (mem_we_b),
        .mem_addr   (mem_addr_b),
        .mem_be     (mem_be_b),
        .mem_wdata  (mem_wdata_b),
        .mem_rdata  (mem_rdata_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Memory model: latency 1 for port A, 3-deep read pipe for port B.
    always @(posedge clk) begin
        if (mem_en_a && mem_we_a)
            mem[mem_addr_a] = merge(rd_word(mem_addr_a), mem_wdata_a, mem_be_a);
        if (mem_en_a && !mem_we_a)
            rda_q <= rd_word(mem_addr_a);
        if (mem_en_b && mem_we_b)
            mem[mem_addr_b] = merge(rd_word(mem_addr_b), mem_wdata_b, mem_be_b);
        rdb_pipe[0] <= (mem_en_b && !mem_we_b) ? rd_word(mem_addr_b) : 32'hDEAD_BEEF;
        rdb_pipe[1] <= rdb_pipe[0];
        rdb_pipe[2] <= rdb_pipe[1];
    end

    assign mem_rdata_a = rda_q;
    assign mem_rdata_b = rdb_pipe[2];

    always @(negedge clk) begin
        if (resp_valid_a) begin
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL sb_a_unexpected: resp rdata=%h exc=%b, none expected",
                         resp_rdata_a, addr_exc_a);
            end else begin
                ea = q_a.pop_front();
                if (resp_rdata_a !== ea.rdata || addr_exc_a !== ea.exc) begin
                    fails++;
                    $display("FAIL sb_a: got rdata=%h exc=%b, want rdata=%h exc=%b",
                             resp_rdata_a, addr_exc_a, ea.rdata, ea.exc);
                end
            end
        end
        if (resp_valid_b) begin
            tests++;
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL sb_b_unexpected: resp rdata=%h exc=%b, none expected",
                         resp_rdata_b, addr_exc_b);
            end else begin
                eb = q_b.pop_front();
                if (resp_rdata_b !== eb.rdata || addr_exc_b !== eb.exc) begin
                    fails++;
                    $display("FAIL sb_b: got rdata=%h exc=%b, want rdata=%h exc=%b",
                             resp_rdata_b, addr_exc_b, eb.rdata, eb.exc);
                end
            end
        end
    end

    task automatic run(input bit sel, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold, output obs_t o);
        o.lat = -1;
        o.en_at = -1;
        o.stall_cnt = 0;
        o.en_cnt = 0;
        o.maddr = 32'h0;
        o.mbe = 4'h0;
        o.mwd = 32'h0;
        o.mwe = 1'b0;
        @(posedge clk);
        #1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        if (sel) valid_b = 1'b1;
        else valid_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel ? stall_b : stall_a) o.stall_cnt++;
            if (sel ? mem_en_b : mem_en_a) begin
                o.en_cnt++;
                o.en_at = k;
                o.maddr = sel ? mem_addr_b : mem_addr_a;
                o.mbe = sel ? mem_be_b : mem_be_a;
                o.mwd = sel ? mem_wdata_b : mem_wdata_a;
                o.mwe = sel ? mem_we_b : mem_we_a;
            end
            if (sel ? resp_valid_b : resp_valid_a) begin
                o.lat = k;
                break;
            end
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({stall_a, resp_valid_a, mem_en_a, mem_we_a, addr_exc_a} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags_a: got %b want 00000",
                     {stall_a, resp_valid_a, mem_en_a, mem_we_a, addr_exc_a});
        end
        tests++;
        if ({mem_addr_a, mem_be_a, mem_wdata_a, resp_rdata_a} !== 100'b0) begin
            fails++;
            $display("FAIL reset_data_a: addr=%h be=%b wd=%h rd=%h want 0",
                     mem_addr_a, mem_be_a, mem_wdata_a, resp_rdata_a);
        end
        tests++;
        if ({stall_b, resp_valid_b, mem_en_b, mem_we_b, addr_exc_b} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags_b: got %b want 00000",
                     {stall_b, resp_valid_b, mem_en_b, mem_we_b, addr_exc_b});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({mem_en_a, stall_a, mem_en_b, stall_b} !== 4'b0) begin
                fails++;
                $display("FAIL idle_quiet: cycle %0d got %b want 0000", k,
                         {mem_en_a, stall_a, mem_en_b, stall_b});
            end
        end
    endtask

    task automatic test_store();
        obs_t o;
        q_a.push_back(exp_t'({32'h0, 1'b0}));
        run(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1'b0, o);
        tests++;
        if (o.lat !== 2 || o.stall_cnt !== 2) begin
            fails++;
            $display("FAIL sb_store_timing: lat=%0d stall=%0d want 2/2", o.lat, o.stall_cnt);
        end
        tests++;
        if (o.en_cnt !== 1 || o.en_at !== 1 || o.mwe !== 1'b1) begin
            fails++;
            $display("FAIL sb_store_en: cnt=%0d at=%0d we=%b want 1/1/1",
                     o.en_cnt, o.en_at, o.mwe);
        end
        tests++;
        if (o.maddr !== 32'h1000 || o.mbe !== 4'b1000 || o.mwd !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL sb_store_lanes: addr=%h be=%b wd=%h want 00001000/1000/a5a5a5a5",
                     o.maddr, o.mbe, o.mwd);
        end
        q_a.push_back(exp_t'({32'h0, 1'b0}));
        run(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_1006, 32'h1234_BEEF, 1'b0, o);
        tests++;
        if (o.maddr !== 32'h1004 || o.mbe !== 4'b1100 || o.mwd !== 32'hBEEF_BEEF) begin
            fails++;
            $display("FAIL sh_store_lanes: addr=%h be=%b wd=%h want 00001004/1100/beefbeef",
                     o.maddr, o.mbe, o.mwd);
        end
        q_a.push_back(exp_t'({32'h0, 1'b0}));
        run(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_2000, 32'h1234_F678, 1'b0, o);
        tests++;
        if (o.mbe !== 4'b1111 || o.mwd !== 32'h1234_F678 || o.lat !== 2) begin
            fails++;
            $display("FAIL sw_store: be=%b wd=%h lat=%0d want 1111/1234f678/2",
                     o.mbe, o.mwd, o.lat);
        end
    endtask

    task automatic test_load_byte();
        obs_t o;
        q_a.push_back(exp_t'({32'hFFFF_FFF6, 1'b0}));
        run(1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 1'b0, o);
        tests++;
        if (o.lat !== 3 || o.stall_cnt !== 3) begin
            fails++;
            $display("FAIL lb_timing: lat=%0d stall=%0d want 3/3", o.lat, o.stall_cnt);
        end
        tests++;
        if (o.maddr !== 32'h2000 || o.mbe !== 4'b1111 || o.mwe !== 1'b0 || o.en_at !== 1) begin
            fails++;
            $display("FAIL lb_issue: addr=%h be=%b we=%b at=%0d want 00002000/1111/0/1",
                     o.maddr, o.mbe, o.mwe, o.en_at);
        end
        q_a.push_back(exp_t'({32'h0000_00F6, 1'b0}));
        run(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 1'b0, o);
    endtask

    task automatic test_load_half();
        obs_t o;
        logic [1:0]  sz  [6] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
        logic        sg  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad  [6] = '{32'h2002, 32'h2000, 32'h2000, 32'h2003, 32'h2000, 32'h2000};
        logic [31:0] exv [6] = '{32'hFFFF_8001, 32'h0000_ABCD, 32'h8001_ABCD,
                                 32'hFFFF_FF80, 32'hFFFF_ABCD, 32'h0000_00CD};
        q_a.push_back(exp_t'({32'h0, 1'b0}));
        run(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_2000, 32'h8001_ABCD, 1'b0, o);
        for (int i = 0; i < 6; i++) begin
            q_a.push_back(exp_t'({exv[i], 1'b0}));
            run(1'b0, 1'b0, sz[i], sg[i], ad[i], 32'hFFFF_FFFF, 1'b0, o);
            tests++;
            if (o.lat !== 3) begin
                fails++;
                $display("FAIL lh_lat[%0d]: lat=%0d want 3", i, o.lat);
            end
        end
        q_a.push_back(exp_t'({32'hA500_0000, 1'b0}));
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 1'b0, o);
        q_a.push_back(exp_t'({32'hFFFF_BEEF, 1'b0}));
        run(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_1006, 32'h0, 1'b0, o);
    endtask

    task automatic test_misaligned();
        obs_t o;
        logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [31:0] ad [4] = '{32'h3001, 32'h3002, 32'h3000, 32'h3003};
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(exp_t'({32'h0, 1'b1}));
            run(1'b0, we[i], sz[i], 1'b1, ad[i], 32'h5555_AAAA, 1'b0, o);
            tests++;
            if (o.lat !== 1 || o.stall_cnt !== 1 || o.en_cnt !== 0) begin
                fails++;
                $display("FAIL misalign[%0d]: lat=%0d stall=%0d en=%0d want 1/1/0",
                         i, o.lat, o.stall_cnt, o.en_cnt);
            end
        end
        tests++;
        if (mem.exists(32'h3000)) begin
            fails++;
            $display("FAIL misalign_write: word 00003000 written to %h, want untouched",
                     mem[32'h3000]);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        q_b.push_back(exp_t'({32'h8001_ABCD, 1'b0}));
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0, 1'b1, o1);
        q_b.push_back(exp_t'({32'h0000_0001, 1'b0}));
        run(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'h0, 1'b0, o2);
        tests++;
        if (o1.lat !== 5 || o1.stall_cnt !== 5 || o1.en_at !== 1) begin
            fails++;
            $display("FAIL lat3_first: lat=%0d stall=%0d en_at=%0d want 5/5/1",
                     o1.lat, o1.stall_cnt, o1.en_at);
        end
        tests++;
        if (o2.lat !== 5 || o2.en_at !== 1 || o2.en_cnt !== 1) begin
            fails++;
            $display("FAIL lat3_b2b: lat=%0d en_at=%0d en=%0d want 5/1/1",
                     o2.lat, o2.en_at, o2.en_cnt);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        req_size = 2'd2;
        req_signed = 1'b0;
        req_addr = 32'h0000_2000;
        valid_b = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        valid_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({stall_b, resp_valid_b, mem_en_b, addr_exc_b, mem_be_b} !== 8'b0 ||
                mem_addr_b !== 32'h0 || resp_rdata_b !== 32'h0) begin
                fails++;
                $display("FAIL reset_mid[%0d]: flags=%b addr=%h rd=%h want 0",
                         k, {stall_b, resp_valid_b, mem_en_b, addr_exc_b, mem_be_b},
                         mem_addr_b, resp_rdata_b);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_b.push_back(exp_t'({32'h0, 1'b0}));
        run(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_1008, 32'hCAFE_F00D, 1'b0, o);
        tests++;
        if (o.lat !== 2 || o.en_at !== 1 || o.mbe !== 4'b1111) begin
            fails++;
            $display("FAIL post_reset_store: lat=%0d en_at=%0d be=%b want 2/1/1111",
                     o.lat, o.en_at, o.mbe);
        end
        q_a.push_back(exp_t'({32'hCAFE_F00D, 1'b0}));
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1008, 32'h0, 1'b0, o);
    endtask

    initial begin
        valid_a = 1'b0;
        valid_b = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        reset = 1'b1;
        test_reset();
        test_store();
        test_load_byte();
        test_load_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: pending a=%0d b=%0d want 0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
